instr_encode_loader: RTL and testbench

//  Sequential instruction writer that feeds the pipeline's instruction memory.

---
 rtl/instr_encode_loader.sv | 151 +++++++++++++++
 tb/tb_instr_encode_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_encode_loader: encodes symbolic instructions into MIPS words and     |
// | writes them to consecutive instruction-memory addresses.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_op,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [15:0]       i_imm,
  input  logic              i_last,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_ptr_max = '1;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_we, w_we_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic              r_last, w_last_nxt;

  logic              w_legal, w_rtype;
  logic [5:0]        w_op6, w_funct;
  logic [31:0]       w_word;

  // Opcode/funct table matching the decode stage
  always_comb begin
    w_legal = 1'b1;
    w_rtype = 1'b0;
    w_op6   = 6'b000000;
    w_funct = 6'b000000;
    case (i_op)
      4'd0:    begin w_rtype = 1'b1; w_funct = 6'b100000; end
      4'd1:    begin w_rtype = 1'b1; w_funct = 6'b100010; end
      4'd2:    begin w_rtype = 1'b1; w_funct = 6'b100100; end
      4'd3:    begin w_rtype = 1'b1; w_funct = 6'b100101; end
      4'd4:    begin w_rtype = 1'b1; w_funct = 6'b101010; end
      4'd5:    w_op6 = 6'b100011;
      4'd6:    w_op6 = 6'b101011;
      4'd7:    w_op6 = 6'b000100;
      4'd8:    w_op6 = 6'b001000;
      4'd9:    w_op6 = 6'b001100;
      4'd10:   w_op6 = 6'b001101;
      4'd11:   w_op6 = 6'b001010;
      default: w_legal = 1'b0;
    endcase
    w_word = w_rtype ? {6'b000000, i_rs, i_rt, i_rd, 5'b00000, w_funct}
                     : {w_op6, i_rs, i_rt, i_imm};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_error_nxt = r_error;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (i_valid && r_ready) begin
          if (w_legal) begin
            w_state_nxt = S_WRITE;
            w_we_nxt    = 1'b1;
            w_wdata_nxt = w_word;
            w_last_nxt  = i_last;
          end else begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
          end
        end
      end
      S_WRITE: begin
        w_count_nxt = r_count + 1'b1;
        // The last address saturates the pointer instead of wrapping
        if (r_ptr != c_ptr_max) w_ptr_nxt = r_ptr + 1'b1;
        if (r_last || (r_ptr == c_ptr_max)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_ERR;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= c_base;
      r_count <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_wdata <= w_wdata_nxt;
      r_we    <= w_we_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign o_ready      = r_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_ptr;
  assign o_imem_wdata = r_wdata;
  assign o_count      = r_count;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_encode_loader: directed self-checking bench for the loader.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1, valid = 1'b0;
  logic        b_reset = 1'b1, b_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic [15:0] imm = 16'd0;
  logic        last = 1'b0;

  logic        ready, we, done, error;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  count;

  logic        b_ready, b_we, b_done, b_error;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_imm(imm), .i_last(last),
    .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
    .o_count(count), .o_done(done), .o_error(error)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .i_clk(clk), .i_reset(b_reset), .i_valid(b_valid), .o_ready(b_ready),
    .i_op(op), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_imm(imm), .i_last(last),
    .o_imem_we(b_we), .o_imem_addr(b_addr), .o_imem_wdata(b_wdata),
    .o_count(b_count), .o_done(b_done), .o_error(b_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the accept edge (the write cycle)
  task automatic send(input logic [3:0] f_op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                      input logic [4:0] f_rd, input logic [15:0] f_imm, input logic f_last);
    for (int k = 0; k < 16 && ready !== 1'b1; k++) tick();
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL send_ready_wait: ready=%b expected 1", ready); end
    op = f_op; rs = f_rs; rt = f_rt; rd = f_rd; imm = f_imm; last = f_last;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0;
    tick();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_checks++; if (addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", addr); end
    n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done=%b error=%b expected 0 0", done, error); end
    reset = 1'b0;
    tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", ready); end
  endtask

  task automatic test_add();
    reset_dut();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b expected 1", we); end
    n_checks++; if (addr !== 8'd0) begin n_fail++; $display("FAIL add_addr: got %h expected 00", addr); end
    n_checks++; if (wdata !== 32'h00221820) begin n_fail++; $display("FAIL add_wdata: got %h expected 00221820", wdata); end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL add_we_pulse: got %b expected 0", we); end
    n_checks++; if (count !== 9'd1) begin n_fail++; $display("FAIL add_count: got %0d expected 1", count); end
    n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL add_idle: ready=%b done=%b expected 1 0", ready, done); end
  endtask

  task automatic test_lw_beq_last();
    reset_dut();
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 1'b0);
    n_checks++; if (we !== 1'b1 || addr !== 8'd0 || wdata !== 32'h8FA80004) begin
      n_fail++; $display("FAIL lw_write: we=%b addr=%h wdata=%h expected 1 00 8fa80004", we, addr, wdata); end
    tick();
    send(4'd7, 5'd4, 5'd5, 5'd0, 16'hFFFF, 1'b1);
    n_checks++; if (we !== 1'b1 || addr !== 8'd1 || wdata !== 32'h1085FFFF) begin
      n_fail++; $display("FAIL beq_write: we=%b addr=%h wdata=%h expected 1 01 1085ffff", we, addr, wdata); end
    last = 1'b0;
    tick();
    n_checks++; if (done !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL last_done: done=%b ready=%b expected 1 0", done, ready); end
    n_checks++; if (count !== 9'd2) begin n_fail++; $display("FAIL last_count: got %0d expected 2", count); end
    op = 4'd0; valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (we !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL done_ignores_valid: we=%b done=%b expected 0 1", we, done); end
    end
    valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    op = 4'd1; rs = 5'd7; rt = 5'd8; rd = 5'd9; last = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (we !== 1'b1 || ready !== 1'b0 || addr !== i[7:0]) begin
        n_fail++; $display("FAIL b2b_write%0d: we=%b ready=%b addr=%h expected 1 0 %h", i, we, ready, addr, i[7:0]); end
      n_checks++; if (wdata !== 32'h00E84822) begin n_fail++; $display("FAIL b2b_wdata%0d: got %h expected 00e84822", i, wdata); end
      tick();
      n_checks++; if (we !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap%0d: we=%b ready=%b expected 0 1", i, we, ready); end
    end
    valid = 1'b0;
    n_checks++; if (count !== 9'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", count); end
  endtask

  task automatic test_illegal();
    reset_dut();
    op = 4'hF; valid = 1'b1;
    tick();
    op = 4'd0;
    n_checks++; if (we !== 1'b0 || error !== 1'b1 || ready !== 1'b0) begin
      n_fail++; $display("FAIL illegal_err: we=%b error=%b ready=%b expected 0 1 0", we, error, ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (we !== 1'b0 || ready !== 1'b0 || error !== 1'b1) begin
        n_fail++; $display("FAIL illegal_stuck: we=%b ready=%b error=%b expected 0 0 1", we, ready, error); end
    end
    valid = 1'b0;
    n_checks++; if (count !== 9'd0 || addr !== 8'd0) begin n_fail++; $display("FAIL illegal_ptr: count=%0d addr=%h expected 0 00", count, addr); end
  endtask

  task automatic test_full_memory();
    b_reset = 1'b1; b_valid = 1'b0;
    tick();
    b_reset = 1'b0;
    tick();
    op = 4'd8; rs = 5'd1; rt = 5'd2; last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16 && b_ready !== 1'b1; k++) tick();
      imm = 16'(i);
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      n_checks++; if (b_we !== 1'b1 || b_addr !== i[1:0] || b_wdata !== (32'h20220000 | i)) begin
        n_fail++; $display("FAIL full_write%0d: we=%b addr=%0d wdata=%h expected 1 %0d %h", i, b_we, b_addr, b_wdata, i, 32'h20220000 | i); end
      tick();
    end
    n_checks++; if (b_count !== 3'd4 || b_done !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_done: count=%0d done=%b ready=%b expected 4 1 0", b_count, b_done, b_ready); end
    b_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (b_we !== 1'b0) begin n_fail++; $display("FAIL full_fifth_ignored: we=%b expected 0", b_we); end
    end
    b_valid = 1'b0;
    n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("FAIL full_count_hold: got %0d expected 4", b_count); end
  endtask

  task automatic test_reset_mid_write();
    reset_dut();
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
    tick();
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
    n_checks++; if (we !== 1'b1 || addr !== 8'd1) begin n_fail++; $display("FAIL mid_second_write: we=%b addr=%h expected 1 01", we, addr); end
    reset = 1'b1;
    tick();
    n_checks++; if (we !== 1'b0 || count !== 9'd0 || addr !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset: we=%b count=%0d addr=%h expected 0 0 00", we, count, addr); end
    reset = 1'b0;
    tick();
    send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
    n_checks++; if (we !== 1'b1 || addr !== 8'd0 || wdata !== 32'h0022182A) begin
      n_fail++; $display("FAIL mid_rewrite: we=%b addr=%h wdata=%h expected 1 00 0022182a", we, addr, wdata); end
    tick();
    n_checks++; if (count !== 9'd1) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_beq_last();
    test_back_to_back();
    test_illegal();
    test_full_memory();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
